// File: rtl/dac_ad5668_rx_model.sv
// ---------------------------------------------------------------------------
// dac_ad5668_rx_model
// Behavioural-but-synthesizable receiver model of an AD5668 style octal DAC
// serial port. It oversamples the asynchronous SCLK/SYNC/DIN lines with the
// system clock, assembles 32-bit frames MSB first (sampled on SCLK falling
// edges), decodes the command and updates the input/DAC registers and the
// power-down mask.
//
// Ports
//   CLK           system clock, rising edge
//   RST_N         asynchronous active-low reset
//   SCLK          serial clock from the interface master (asynchronous)
//   SYNC          frame select, active-low (asynchronous)
//   DIN           serial data, MSB first
//   rd_ch         channel select for readback
//   frame_valid   one-CLK pulse per complete 32-bit frame
//   frame_cmd     command field (bits 27:24) of the last valid frame
//   frame_addr    address field (bits 23:20) of the last valid frame
//   frame_data    data field (bits 19:4) of the last valid frame
//   frame_abort   one-CLK pulse when SYNC rises before 32 bits arrived
//   rd_input_reg  input register of channel rd_ch (combinational)
//   rd_dac_reg    DAC register of channel rd_ch (combinational)
//   pd_mask       per-channel power-down flags, bit n = channel n
// ---------------------------------------------------------------------------
module dac_ad5668_rx_model #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SCLK,
  input  logic        SYNC,
  input  logic        DIN,
  input  logic [2:0]  rd_ch,
  output logic        frame_valid,
  output logic [3:0]  frame_cmd,
  output logic [3:0]  frame_addr,
  output logic [15:0] frame_data,
  output logic        frame_abort,
  output logic [15:0] rd_input_reg,
  output logic [15:0] rd_dac_reg,
  output logic [7:0]  pd_mask
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_DECODE  = 2'd2,
    ST_WAIT_HI = 2'd3
  } state_t;

  // Synchronizer chains, shifted in at bit 0 and used from the MSB.
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] sync_sync_r;
  logic [SYNC_STAGES-1:0] din_sync_r;
  // Fills with ones after reset; all-ones means the chains carry real samples.
  logic [SYNC_STAGES-1:0] fill_r;
  logic                   sclk_prev_r;
  logic                   armed_r;

  logic sclk_s;
  logic sync_s;
  logic din_s;
  logic fall_s;
  logic chain_full_s;

  state_t      state_r;
  state_t      state_nx_s;
  logic [5:0]  cnt_r;
  logic [5:0]  cnt_nx_s;
  logic [31:0] shift_r;
  logic [31:0] shift_nx_s;
  logic        enter_decode_s;
  logic        abort_s;

  logic        frame_valid_r;
  logic        frame_abort_r;
  logic [3:0]  frame_cmd_r;
  logic [3:0]  frame_addr_r;
  logic [15:0] frame_data_r;
  logic [7:0]  pd_mask_r;
  logic [15:0] input_reg_r [8];
  logic [15:0] dac_reg_r   [8];
  logic [7:0]  tgt_s;

  // Header and trailer nibbles carry no meaning for this device.
  logic unused_bits_s;
  assign unused_bits_s = ^{shift_nx_s[31:28], shift_nx_s[3:0]};

  assign sclk_s       = sclk_sync_r[SYNC_STAGES-1];
  assign sync_s       = sync_sync_r[SYNC_STAGES-1];
  assign din_s        = din_sync_r[SYNC_STAGES-1];
  assign fall_s       = sclk_prev_r & ~sclk_s;
  assign chain_full_s = &fill_r;

  // Input synchronizers, falling-edge history and post-reset arming flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sclk_sync_r <= {SYNC_STAGES{1'b1}};
      sync_sync_r <= {SYNC_STAGES{1'b1}};
      din_sync_r  <= {SYNC_STAGES{1'b0}};
      fill_r      <= {SYNC_STAGES{1'b0}};
      sclk_prev_r <= 1'b1;
      armed_r     <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SCLK};
      sync_sync_r <= {sync_sync_r[SYNC_STAGES-2:0], SYNC};
      din_sync_r  <= {din_sync_r[SYNC_STAGES-2:0], DIN};
      fill_r      <= {fill_r[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_r <= sclk_s;
      // A new frame needs SYNC genuinely observed high after reset, so the
      // reset value of the chain must not count.
      armed_r     <= armed_r | (chain_full_s & sync_s);
    end
  end

  // Next-state logic for the frame receiver.
  always_comb begin
    state_nx_s     = state_r;
    cnt_nx_s       = cnt_r;
    shift_nx_s     = shift_r;
    enter_decode_s = 1'b0;
    abort_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (armed_r && !sync_s) begin
          state_nx_s = ST_SHIFT;
          cnt_nx_s   = 6'd0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (sync_s) begin
          state_nx_s = ST_IDLE;
          abort_s    = 1'b1;
        end else if (fall_s) begin
          shift_nx_s = {shift_r[30:0], din_s};
          cnt_nx_s   = cnt_r + 6'd1;
          if (cnt_r == 6'd31) begin
            state_nx_s     = ST_DECODE;
            enter_decode_s = 1'b1;
          end else begin
            state_nx_s = ST_SHIFT;
          end
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_DECODE: begin
        state_nx_s = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (sync_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_WAIT_HI;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Receiver state, bit counter, shift register and frame field outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 6'd0;
      shift_r       <= 32'd0;
      frame_valid_r <= 1'b0;
      frame_abort_r <= 1'b0;
      frame_cmd_r   <= 4'd0;
      frame_addr_r  <= 4'd0;
      frame_data_r  <= 16'd0;
    end else begin
      state_r       <= state_nx_s;
      cnt_r         <= cnt_nx_s;
      shift_r       <= shift_nx_s;
      // Registered so the pulse and the new fields coincide with DECODE.
      frame_valid_r <= enter_decode_s;
      frame_abort_r <= abort_s;
      if (enter_decode_s) begin
        frame_cmd_r  <= shift_nx_s[27:24];
        frame_addr_r <= shift_nx_s[23:20];
        frame_data_r <= shift_nx_s[19:4];
      end
    end
  end

  // Channel target mask: single channel for 0..7, broadcast for F, none else.
  always_comb begin
    tgt_s = 8'h00;
    if (frame_addr_r == 4'hF) begin
      tgt_s = 8'hFF;
    end else if (!frame_addr_r[3]) begin
      tgt_s = 8'h01 << frame_addr_r[2:0];
    end else begin
      tgt_s = 8'h00;
    end
  end

  // Register file and power-down mask, updated at the end of DECODE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int n = 0; n < 8; n++) begin
        input_reg_r[n] <= 16'd0;
        dac_reg_r[n]   <= 16'd0;
      end
      pd_mask_r <= 8'h00;
    end else if (state_r == ST_DECODE) begin
      case (frame_cmd_r)
        4'h0: begin
          for (int n = 0; n < 8; n++) begin
            if (tgt_s[n]) input_reg_r[n] <= frame_data_r;
          end
        end
        4'h1: begin
          for (int n = 0; n < 8; n++) begin
            if (tgt_s[n]) dac_reg_r[n] <= input_reg_r[n];
          end
        end
        4'h2: begin
          // Untargeted channels transfer their old input value.
          for (int n = 0; n < 8; n++) begin
            if (tgt_s[n]) begin
              input_reg_r[n] <= frame_data_r;
              dac_reg_r[n]   <= frame_data_r;
            end else begin
              dac_reg_r[n]   <= input_reg_r[n];
            end
          end
        end
        4'h3: begin
          for (int n = 0; n < 8; n++) begin
            if (tgt_s[n]) begin
              input_reg_r[n] <= frame_data_r;
              dac_reg_r[n]   <= frame_data_r;
            end
          end
        end
        4'h4: begin
          // data[9:8] selects power-down vs power-up for the flagged channels.
          for (int n = 0; n < 8; n++) begin
            if (frame_data_r[n]) pd_mask_r[n] <= |frame_data_r[9:8];
          end
        end
        4'h7: begin
          for (int n = 0; n < 8; n++) begin
            input_reg_r[n] <= 16'd0;
            dac_reg_r[n]   <= 16'd0;
          end
          pd_mask_r <= 8'h00;
        end
        default: begin
        end
      endcase
    end
  end

  assign frame_valid  = frame_valid_r;
  assign frame_abort  = frame_abort_r;
  assign frame_cmd    = frame_cmd_r;
  assign frame_addr   = frame_addr_r;
  assign frame_data   = frame_data_r;
  assign pd_mask      = pd_mask_r;
  assign rd_input_reg = input_reg_r[rd_ch];
  assign rd_dac_reg   = dac_reg_r[rd_ch];

endmodule

// File: tb/tb_dac_ad5668_rx_model.sv
// ---------------------------------------------------------------------------
// tb_dac_ad5668_rx_model
// Directed plus randomized frames driven onto SCLK/SYNC/DIN, with outputs
// compared against a channel-level reference model of the DAC registers.
// ---------------------------------------------------------------------------
module tb_dac_ad5668_rx_model;

  localparam int CP = 10;  // CLK period
  localparam int H  = 30;  // SCLK half period (SCLK period = 6 CLK)

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        SCLK = 1'b1;
  logic        SYNC = 1'b1;
  logic        DIN = 1'b0;
  logic [2:0]  rd_ch = 3'd0;
  logic        frame_valid;
  logic [3:0]  frame_cmd;
  logic [3:0]  frame_addr;
  logic [15:0] frame_data;
  logic        frame_abort;
  logic [15:0] rd_input_reg;
  logic [15:0] rd_dac_reg;
  logic [7:0]  pd_mask;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int abort_cnt = 0;
  int exp_valid = 0;
  int exp_abort = 0;

  // Reference model state
  logic [15:0] m_in  [8];
  logic [15:0] m_dac [8];
  logic [7:0]  m_pd;
  logic [3:0]  m_cmd;
  logic [3:0]  m_addr;
  logic [15:0] m_data;

  dac_ad5668_rx_model #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .SCLK(SCLK), .SYNC(SYNC), .DIN(DIN),
    .rd_ch(rd_ch), .frame_valid(frame_valid), .frame_cmd(frame_cmd),
    .frame_addr(frame_addr), .frame_data(frame_data),
    .frame_abort(frame_abort), .rd_input_reg(rd_input_reg),
    .rd_dac_reg(rd_dac_reg), .pd_mask(pd_mask)
  );

  always #(CP/2) CLK = ~CLK;

  // Count high cycles of the pulse outputs; one-cycle pulses make these
  // equal to the number of events.
  always @(posedge CLK) begin
    if (RST_N) begin
      valid_cnt <= valid_cnt + int'(frame_valid);
      abort_cnt <= abort_cnt + int'(frame_abort);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] a, input logic [15:0] d);
    return {4'h0, c, a, d, 4'h0};
  endfunction

  task automatic model_clear();
    for (int n = 0; n < 8; n++) begin
      m_in[n] = 16'd0;
      m_dac[n] = 16'd0;
    end
    m_pd = 8'h00;
  endtask

  // Effect of a complete frame, straight from the command table.
  task automatic model_apply(input logic [31:0] w);
    logic [3:0]  c;
    logic [3:0]  a;
    logic [15:0] d;
    bit          hit [8];
    c = w[27:24];
    a = w[23:20];
    d = w[19:4];
    m_cmd = c;
    m_addr = a;
    m_data = d;
    exp_valid++;
    for (int n = 0; n < 8; n++) hit[n] = (a == 4'hF) || (int'(a) == n);
    case (c)
      4'h0: for (int n = 0; n < 8; n++) if (hit[n]) m_in[n] = d;
      4'h1: for (int n = 0; n < 8; n++) if (hit[n]) m_dac[n] = m_in[n];
      4'h2: begin
        for (int n = 0; n < 8; n++) if (hit[n]) m_in[n] = d;
        for (int n = 0; n < 8; n++) m_dac[n] = m_in[n];
      end
      4'h3: for (int n = 0; n < 8; n++) if (hit[n]) begin m_in[n] = d; m_dac[n] = d; end
      4'h4: for (int n = 0; n < 8; n++) if (d[n]) m_pd[n] = (d[9:8] != 2'b00);
      4'h7: model_clear();
      default: ;
    endcase
  endtask

  // Clocks n bits of w (MSB first) with SYNC left as is; bits past 32 random.
  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      DIN = (i < 32) ? w[31-i] : 1'($urandom);
      #H SCLK = 1'b0;
      #H SCLK = 1'b1;
    end
  endtask

  task automatic send(input logic [31:0] w, input int n);
    SYNC = 1'b0;
    #(2*H);
    shift_bits(w, n);
    #H SYNC = 1'b1;
    #(12*CP);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, valid_cnt, exp_valid);
    check({tag, ".abort"}, abort_cnt, exp_abort);
    check({tag, ".cmd"}, frame_cmd, m_cmd);
    check({tag, ".addr"}, frame_addr, m_addr);
    check({tag, ".data"}, frame_data, m_data);
    check({tag, ".pd"}, pd_mask, m_pd);
    for (int n = 0; n < 8; n++) begin
      rd_ch = 3'(n);
      #1;
      check($sformatf("%s.in%0d", tag, n), rd_input_reg, m_in[n]);
      check($sformatf("%s.dac%0d", tag, n), rd_dac_reg, m_dac[n]);
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [3:0]  c;
    model_clear();
    m_cmd = 4'h0;
    m_addr = 4'h0;
    m_data = 16'h0000;

    // Reset state
    #(3*CP + 1);
    check("rst.valid_o", frame_valid, 1'b0);
    check("rst.abort_o", frame_abort, 1'b0);
    check_all("rst");
    RST_N = 1'b1;
    #(5*CP);

    // Single-channel write-and-update
    w = mk(4'h3, 4'h0, 16'hFFFF);
    send(w, 32); model_apply(w); check_all("f035");

    // Broadcast input write, then single-channel update
    w = mk(4'h0, 4'hF, 16'h1234);
    send(w, 32); model_apply(w); check_all("f036a");
    w = mk(4'h1, 4'h2, 16'h0000);
    send(w, 32); model_apply(w); check_all("f036b");

    // Short frame aborts without changing anything
    send(mk(4'h3, 4'h5, 16'hBEEF), 20); exp_abort++; check_all("abort");

    // Extra SCLK edges in one SYNC window are ignored
    w = mk(4'h3, 4'h1, 16'h00AA);
    send(w, 40); model_apply(w); check_all("extra40");

    // Power-down mask then clear-all
    w = mk(4'h4, 4'h9, 16'h0105);
    send(w, 32); model_apply(w); check_all("pd");
    w = mk(4'h7, 4'h0, 16'h0000);
    send(w, 32); model_apply(w); check_all("clr");

    // Ignored address range
    w = mk(4'h3, 4'hA, 16'h5555);
    send(w, 32); model_apply(w); check_all("addr_ign");

    // Reset mid-frame, SYNC still low after release: must not start a frame
    SYNC = 1'b0;
    #(2*H);
    shift_bits(mk(4'h3, 4'h6, 16'h7777), 16);
    RST_N = 1'b0;
    #(3*CP);
    model_clear();
    m_cmd = 4'h0; m_addr = 4'h0; m_data = 16'h0000;
    RST_N = 1'b1;
    #(5*CP);
    shift_bits(32'hFFFF_FFFF, 4);
    #H SYNC = 1'b1;
    #(12*CP);
    check_all("rst_mid");
    w = mk(4'h3, 4'h7, 16'h8000);
    send(w, 32); model_apply(w); check_all("f040");

    // Randomized frames with random header/trailer nibbles
    for (int k = 0; k < 24; k++) begin
      c = 4'($urandom_range(0, 15));
      if (c == 4'h7 && ($urandom_range(0, 2) != 0)) c = 4'h0;
      w = {4'($urandom), c, 4'($urandom), 16'($urandom), 4'($urandom)};
      if ($urandom_range(0, 7) == 0) begin
        send(w, $urandom_range(1, 31));
        exp_abort++;
      end else begin
        send(w, 32);
        model_apply(w);
      end
      check_all($sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_ad5668_rx_model.md
DAC_AD5668_RX_MODEL -- requirements
Module: dac_ad5668_rx_model

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on SCLK/SYNC/DIN inputs (legal 2..3).
REQ-002 CLK  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 RST_N  input  1  reset, asynchronous and active-low.
REQ-004 SCLK  input  1  serial clock from DAC interface master, asynchronous to CLK, period >= 4 CLK periods.
REQ-005 SYNC  input  1  frame select, active-low, asynchronous to CLK.
REQ-006 DIN  input  1  serial data, MSB first, sampled on SCLK falling edge.
REQ-007 frame_valid  output  1  one-CLK pulse per complete 32-bit frame.
REQ-008 frame_cmd  output  4  command field (frame bits 27:24) of last valid frame.
REQ-009 frame_addr  output  4  address field (bits 23:20) of last valid frame.
REQ-010 frame_data  output  16  data field (bits 19:4) of last valid frame.
REQ-011 frame_abort  output  1  one-CLK pulse when SYNC rises before 32 bits received.
REQ-012 rd_ch  input  3  channel select for register readback.
REQ-013 rd_input_reg  output  16  input register of channel rd_ch, combinational from rd_ch.
REQ-014 rd_dac_reg  output  16  DAC register of channel rd_ch, combinational from rd_ch.
REQ-015 pd_mask  output  8  per-channel power-down flags, bit n = channel n (A=0..H=7).

Function
REQ-016 SCLK, SYNC, DIN SHALL each pass through SYNC_STAGES flops; falling-edge detect on synchronized SCLK SHALL be a one-CLK strobe.
REQ-017 FSM states: IDLE, SHIFT, DECODE, WAIT_HI.
REQ-018 IDLE -> SHIFT when synchronized SYNC low; bit counter (6 bits) cleared to 0.
REQ-019 In SHIFT each SCLK falling strobe SHALL shift synchronized DIN into a 32-bit register LSB side and increment counter.
REQ-020 SHIFT -> DECODE on the strobe making counter 32; DECODE lasts exactly one CLK, then -> WAIT_HI.
REQ-021 SHIFT with SYNC high and counter < 32 -> IDLE, frame_abort pulses one CLK, no register or output change.
REQ-022 WAIT_HI ignores further SCLK edges; -> IDLE when SYNC high; no abort pulse.
REQ-023 frame_valid SHALL pulse in the DECODE cycle; frame_cmd/addr/data update in that same cycle and hold until the next valid frame.
REQ-024 Register effects applied in DECODE, visible on rd_* the next CLK; target = channel addr[2:0] when addr <= 7, all eight when addr = 4'hF, none for addr 8..14.
REQ-025 cmd 0000: input reg(s) <= data.
REQ-026 cmd 0001: DAC reg(s) <= own input reg.
REQ-027 cmd 0010: input reg(s) <= data, then all eight DAC regs <= their input regs (targeted channels take new data).
REQ-028 cmd 0011: input reg(s) and DAC reg(s) <= data.
REQ-029 cmd 0100: pd_mask[n] <= 1 for each data[n] (n=0..7) set when data[9:8] != 00, else pd_mask[n] <= 0 for each set data[n]; address ignored.
REQ-030 cmd 0111: all input regs, DAC regs, pd_mask cleared to 0.
REQ-031 All other commands: frame_valid still pulses, no register effect.
REQ-032 Frame bits 31:28 and 3:0 SHALL be ignored.

Reset
REQ-033 RST_N low SHALL immediately force: FSM IDLE, counter 0, shift reg 0, synchronizer flops to SYNC=1/SCLK=1/DIN=0, frame_valid 0, frame_abort 0, frame_cmd/addr 0, frame_data 0, all registers 0, pd_mask 0.
REQ-034 Reset mid-frame SHALL discard the partial frame without frame_abort; after release, a frame requires a fresh SYNC falling edge (SYNC seen high at least once).

Verification
REQ-035 Frame 0x0_3_0_FFFF_0 (cmd 3, addr 0, data FFFF) -> one frame_valid, rd_ch=0 gives input=DAC=16'hFFFF, other channels 0.
REQ-036 cmd 0 addr F data 1234, then cmd 1 addr 2 -> all input regs 1234, only channel 2 DAC reg 1234, others 0.
REQ-037 SYNC raised after 20 bits -> frame_abort one CLK, no frame_valid, registers unchanged.
REQ-038 40 SCLK edges in one SYNC-low window, cmd 3 addr 1 data 00AA -> single frame_valid, channel 1 = 00AA, extra edges ignored.
REQ-039 cmd 4 data 0x1_05 then cmd 7 -> pd_mask 8'h05, then all registers and pd_mask 0.
REQ-040 RST_N low after 16 bits, released, new full frame cmd 3 addr 7 data 8000 -> no abort, channel 7 = 8000.
